// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator sequencer: FSM state encoding and Q2.29 helpers.
package osc_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } osc_state_t;

    // Integer value expressed as a Q2.29 fixed-point word.
    function automatic logic signed [DATA_W-1:0] q_from_int(input int v);
        return DATA_W'(v) <<< FRAC_W;
    endfunction

endpackage

// File: rtl/osc_tick_div.sv
// Sample-period divider: emits a one-cycle registered tick every div+1 counted cycles.
module osc_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             Fg_CLK,
    input  logic             RESETn,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_eff;

    // A clear counts as the first cycle of a fresh period, so the first tick lands div+1 cycles later.
    assign cnt_eff = clr ? '0 : cnt;

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr || en) begin
            if (cnt_eff == div) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt_eff + DIV_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/osc_sequencer.sv
// Control stage ahead of the recursive sine oscillator: coefficient handshake,
// seed/tick generation and zero-crossing-aligned coefficient reloads.
module osc_sequencer #(
    parameter int DATA_W     = 32,
    parameter int DIV_W      = 16,
    parameter int ZC_TIMEOUT = 1024
) (
    input  logic                     Fg_CLK,
    input  logic                     RESETn,
    input  logic                     Run,
    input  logic                     Cfg_Valid,
    output logic                     Cfg_Ready,
    input  logic signed [DATA_W-1:0] Cfg_Init1,
    input  logic signed [DATA_W-1:0] Cfg_Init2,
    input  logic        [DIV_W-1:0]  Cfg_Div,
    input  logic signed [DATA_W-1:0] Osc_Out1,
    output logic                     Osc_Ready,
    output logic                     Osc_Enable,
    output logic signed [DATA_W-1:0] Osc_Init1,
    output logic signed [DATA_W-1:0] Osc_Init2,
    output logic                     Running
);
    import osc_pkg::*;

    localparam int TO_W = $clog2(ZC_TIMEOUT + 1);

    function automatic logic is_neg(input logic signed [DATA_W-1:0] x);
        return x < 0;
    endfunction

    osc_state_t               state, state_nxt;
    logic                     pending, loaded, copy, accept;
    logic signed [DATA_W-1:0] sh_init1, sh_init2, act_init1, act_init2;
    logic        [DIV_W-1:0]  sh_div, act_div;
    logic                     prev_neg, hist_vld, zc, to_hit;
    logic        [TO_W-1:0]   tcnt;
    logic                     div_clr, div_en;

    assign Cfg_Ready = ~pending;
    assign accept    = Cfg_Valid & ~pending;
    assign Osc_Init1 = act_init1;
    assign Osc_Init2 = act_init2;

    assign zc     = hist_vld & prev_neg & ~is_neg(Osc_Out1);
    assign to_hit = 32'(tcnt) >= 32'(ZC_TIMEOUT - 1);

    // The divider only advances while the FSM stays in RUN, so a stop or reload suppresses the next tick.
    assign div_clr = (state == ST_LOAD) && (state_nxt == ST_RUN);
    assign div_en  = (state == ST_RUN)  && (state_nxt == ST_RUN);

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        copy      = 1'b0;
        if (!Run) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (pending || loaded) begin
                    state_nxt = ST_LOAD;
                    copy      = pending;
                end
                ST_LOAD: state_nxt = ST_RUN;
                ST_RUN: if (Osc_Enable && pending && (zc || to_hit)) begin
                    state_nxt = ST_LOAD;
                    copy      = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (accept) begin
            sh_init1 <= Cfg_Init1;
            sh_init2 <= Cfg_Init2;
            sh_div   <= Cfg_Div;
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (!RESETn) begin
            pending   <= 1'b0;
            loaded    <= 1'b0;
            act_init1 <= '0;
            act_init2 <= '0;
            act_div   <= '0;
            Osc_Ready <= 1'b0;
            Running   <= 1'b0;
            prev_neg  <= 1'b0;
            hist_vld  <= 1'b0;
            tcnt      <= '0;
        end else begin
            if (copy) begin
                pending   <= 1'b0;
                act_init1 <= sh_init1;
                act_init2 <= sh_init2;
                act_div   <= sh_div;
            end else if (accept) begin
                pending <= 1'b1;
            end
            if (state_nxt == ST_LOAD) loaded <= 1'b1;
            Osc_Ready <= (state_nxt == ST_LOAD);
            Running   <= (state_nxt != ST_IDLE);
            // Sign history and timeout restart with every seed; both advance only on sample ticks.
            if (state == ST_LOAD) begin
                hist_vld <= 1'b0;
                tcnt     <= '0;
            end else if (state == ST_RUN && Osc_Enable) begin
                prev_neg <= is_neg(Osc_Out1);
                hist_vld <= 1'b1;
                if (pending && 32'(tcnt) < 32'(ZC_TIMEOUT)) tcnt <= tcnt + TO_W'(1);
            end
        end
    end

    osc_tick_div #(
        .DIV_W(DIV_W)
    ) u_tick_div (
        .Fg_CLK (Fg_CLK),
        .RESETn (RESETn),
        .clr    (div_clr),
        .en     (div_en),
        .div    (act_div),
        .tick   (Osc_Enable)
    );

endmodule

// File: tb/tb_osc_sequencer.sv
// Scoreboard bench for osc_sequencer: expected Ready/Enable events are queued by the stimulus and matched by a monitor.
module tb_osc_sequencer;
    import osc_pkg::*;

    localparam int EV_RDY = 1;
    localparam int EV_EN  = 2;

    logic               Fg_CLK = 1'b0;
    logic               RESETn, Run, Cfg_Valid, Cfg_Ready;
    logic signed [31:0] Cfg_Init1, Cfg_Init2, Osc_Out1, Osc_Init1, Osc_Init2;
    logic        [15:0] Cfg_Div;
    logic               Osc_Ready, Osc_Enable, Running;

    osc_sequencer #(
        .DATA_W     (32),
        .DIV_W      (16),
        .ZC_TIMEOUT (8)
    ) dut (
        .Fg_CLK     (Fg_CLK),
        .RESETn     (RESETn),
        .Run        (Run),
        .Cfg_Valid  (Cfg_Valid),
        .Cfg_Ready  (Cfg_Ready),
        .Cfg_Init1  (Cfg_Init1),
        .Cfg_Init2  (Cfg_Init2),
        .Cfg_Div    (Cfg_Div),
        .Osc_Out1   (Osc_Out1),
        .Osc_Ready  (Osc_Ready),
        .Osc_Enable (Osc_Enable),
        .Osc_Init1  (Osc_Init1),
        .Osc_Init2  (Osc_Init2),
        .Running    (Running)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    int cyc = 0;
    always @(posedge Fg_CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] i1;
        logic [31:0] i2;
    } ev_t;
    ev_t exp_q[$];

    localparam logic [31:0] A1 = 32'h0C7C_5C1E, A2 = 32'h3EC5_2F9F;
    localparam logic [31:0] B1 = 32'h1000_0000, C1 = 32'h0200_0000, C2 = 32'h3FF0_0000;
    localparam logic [31:0] D1 = 32'h0080_0000, D2 = 32'h3FFF_0000;
    logic [31:0] B2;

    task automatic push_ev(input int kind, input int c, input logic [31:0] i1, input logic [31:0] i2);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.i1   = i1;
        e.i2   = i2;
        exp_q.push_back(e);
    endtask

    task automatic push_en(input int first, input int step, input int n);
        for (int i = 0; i < n; i++) push_ev(EV_EN, first + i * step, 32'h0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d at cycle %0d, expected no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_RDY && (Osc_Init1 !== e.i1 || Osc_Init2 !== e.i2))) begin
                errors++;
                $display("FAIL event: got kind=%0d cycle=%0d init1=%h init2=%h, expected kind=%0d cycle=%0d init1=%h init2=%h",
                         kind, cyc, Osc_Init1, Osc_Init2, e.kind, e.cyc, e.i1, e.i2);
            end
        end
    endtask

    always @(negedge Fg_CLK) begin
        if (Osc_Ready === 1'b1)  check_event(EV_RDY);
        if (Osc_Enable === 1'b1) check_event(EV_EN);
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge Fg_CLK);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_osc_ready"}, 32'(Osc_Ready), 32'h0);
        chk({tag, "_osc_enable"}, 32'(Osc_Enable), 32'h0);
        chk({tag, "_running"}, 32'(Running), 32'h0);
        chk({tag, "_init1"}, Osc_Init1, 32'h0);
        chk({tag, "_init2"}, Osc_Init2, 32'h0);
        chk({tag, "_cfg_ready"}, 32'(Cfg_Ready), 32'h1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        B2 = q_from_int(1);
        RESETn = 1'b0; Run = 1'b0; Cfg_Valid = 1'b0;
        Cfg_Init1 = '0; Cfg_Init2 = '0; Cfg_Div = '0; Osc_Out1 = 32'sd100;
        repeat (3) @(negedge Fg_CLK);
        check_reset_state("reset");
        RESETn = 1'b1;
        @(negedge Fg_CLK);

        // Start-up seed, steady ticks, ZC reload, timeout reload, stop/restart.
        a = cyc;
        Cfg_Valid = 1'b1; Cfg_Init1 = A1; Cfg_Init2 = A2; Cfg_Div = 16'd3; Run = 1'b1;
        push_ev(EV_RDY, a + 2, A1, A2);
        push_en(a + 6, 4, 3);
        push_ev(EV_RDY, a + 15, B1, B2);
        push_en(a + 19, 4, 8);
        push_ev(EV_RDY, a + 48, C1, C2);
        push_en(a + 50, 2, 3);
        push_ev(EV_RDY, a + 61, C1, C2);
        push_en(a + 63, 2, 2);

        wait_cyc(a + 1);
        chk("t2_cfg_ready_while_pending", 32'(Cfg_Ready), 32'h0);
        Cfg_Init1 = B1; Cfg_Init2 = B2; Cfg_Div = 16'd3;
        wait_cyc(a + 2);
        chk("t2_cfg_ready_after_copy", 32'(Cfg_Ready), 32'h1);
        chk("t1_running", 32'(Running), 32'h1);
        wait_cyc(a + 3);
        chk("t2_second_set_accepted", 32'(Cfg_Ready), 32'h0);
        Cfg_Valid = 1'b0;
        Osc_Out1 = -32'sd5;
        wait_cyc(a + 7);
        Osc_Out1 = -32'sd1;
        wait_cyc(a + 11);
        Osc_Out1 = 32'sd0;
        wait_cyc(a + 14);
        chk("t3_pending_before_zc", 32'(Cfg_Ready), 32'h0);
        wait_cyc(a + 15);
        chk("t3_cfg_ready_after_zc", 32'(Cfg_Ready), 32'h1);
        Osc_Out1 = 32'sd100;
        wait_cyc(a + 16);
        chk("t3_init1_applied", Osc_Init1, B1);
        Cfg_Valid = 1'b1; Cfg_Init1 = C1; Cfg_Init2 = C2; Cfg_Div = 16'd1;
        wait_cyc(a + 17);
        Cfg_Valid = 1'b0;
        chk("t4_cfg_pending", 32'(Cfg_Ready), 32'h0);
        wait_cyc(a + 47);
        chk("t4_pending_at_8th_tick", 32'(Cfg_Ready), 32'h0);
        chk("t4_active_kept_until_reload", Osc_Init2, B2);
        wait_cyc(a + 48);
        chk("t4_cfg_ready_after_timeout", 32'(Cfg_Ready), 32'h1);
        wait_cyc(a + 54);
        Run = 1'b0;
        wait_cyc(a + 55);
        chk("t5_running_off", 32'(Running), 32'h0);
        chk("t5_enable_off", 32'(Osc_Enable), 32'h0);
        wait_cyc(a + 60);
        Run = 1'b1;
        wait_cyc(a + 65);
        RESETn = 1'b0;
        wait_cyc(a + 66);
        RESETn = 1'b1;
        check_reset_state("t6_midrun_reset");
        wait_cyc(a + 72);
        chk("t6_no_restart", 32'(Running), 32'h0);
        Run = 1'b0;

        // Div=0: a tick on every RUN cycle, ending as soon as Run drops.
        b = a + 73;
        wait_cyc(b);
        Cfg_Valid = 1'b1; Cfg_Init1 = D1; Cfg_Init2 = D2; Cfg_Div = 16'd0; Run = 1'b1;
        push_ev(EV_RDY, b + 2, D1, D2);
        push_en(b + 3, 1, 4);
        wait_cyc(b + 1);
        Cfg_Valid = 1'b0;
        wait_cyc(b + 6);
        Run = 1'b0;
        wait_cyc(b + 10);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
